log_2_approx: RTL and testbench



---
 rtl/log_2_approx.sv | 102 ++++++++++
 tb/tb_log_2_approx.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/log_2_approx.sv
// log_2_approx: fixed-point base-2 logarithm (Mitchell approximation).
// Input is unsigned Q4.12 and output is signed Q4.12. The result is registered
// in a single stage with a strobe/valid handshake, and the operand is forwarded
// alongside the result.
// Optional feature: define LOG2_APPROX_CORR_EN to add a quadratic mantissa
// correction before the output register.
module log_2_approx (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        ready,
  input  logic [15:0] in_x,
  output logic [15:0] log2_x,
  output logic        valid,
  output logic [15:0] out_x
);

  // Saturated result for operands whose true log2 is below -8 (including zero).
  localparam logic [15:0] SatVal = 16'h8000;

  logic [3:0]  lead_pos;   // position p of the leading one
  logic        sat;        // operand too small to represent
  logic [15:0] norm_x;     // operand shifted so the leading one sits at bit 15
  logic [11:0] frac;       // Mitchell mantissa f
  logic [11:0] frac_out;   // mantissa after optional correction
  logic [3:0]  int_field;  // two's-complement integer part, p - 12
  logic [15:0] log2_d;

  logic [15:0] log2_q;
  logic [15:0] out_x_q;
  logic        valid_q;

  // Priority encoder: the highest set bit wins.
  always_comb begin
    lead_pos = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (in_x[i]) begin
        lead_pos = 4'(i);
      end
    end
  end

  // Zero, and any operand whose leading one is below bit 4, both have an
  // empty top 12 bits.
  assign sat = (in_x[15:4] == 12'd0);

  // Left-align the operand. The bits just below the leading one become the fraction.
  assign norm_x = in_x << (4'd15 - lead_pos);
  assign frac   = 12'(norm_x >> 3);

  // p - 12 modulo 16 is the same as p + 4 in four bits.
  assign int_field = lead_pos + 4'd4;

`ifdef LOG2_APPROX_CORR_EN
  logic [12:0] one_minus_f;
  logic [24:0] prod;
  logic [12:0] g;
  logic [12:0] corr;
  logic [12:0] frac_sum;

  // The correction term is about 0.34375 * f * (1 - f), with each shifted term truncated.
  always_comb begin
    one_minus_f = 13'd4096 - {1'b0, frac};
    prod        = 25'(frac) * 25'(one_minus_f);
    g           = 13'(prod >> 12);
    corr        = (g >> 2) + (g >> 4) + (g >> 5);
    frac_sum    = {1'b0, frac} + corr;
    // The peak correction keeps the sum below 4096, so the top bit is never set.
    frac_out    = 12'(frac_sum);
  end
`else
  assign frac_out = frac;
`endif

  // Select the saturated value or the integer/fraction concatenation.
  always_comb begin
    log2_d = {int_field, frac_out};
    if (sat) begin
      log2_d = SatVal;
    end
  end

  // Output stage: en freezes everything, and ready gates capture of new data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      log2_q  <= 16'h0000;
      out_x_q <= 16'h0000;
      valid_q <= 1'b0;
    end else if (en) begin
      valid_q <= ready;
      if (ready) begin
        log2_q  <= log2_d;
        out_x_q <= in_x;
      end
    end
  end

  assign log2_x = log2_q;
  assign out_x  = out_x_q;
  assign valid  = valid_q;

endmodule

// File: tb/tb_log_2_approx.sv
// Directed self-checking bench for log_2_approx.
module tb_log_2_approx;

  logic        clk;
  logic        rst;
  logic        en;
  logic        ready;
  logic [15:0] in_x;
  logic [15:0] log2_x;
  logic        valid;
  logic [15:0] out_x;

  int checks = 0;
  int errors = 0;

  log_2_approx dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .ready  (ready),
    .in_x   (in_x),
    .log2_x (log2_x),
    .valid  (valid),
    .out_x  (out_x)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply a single-cycle strobe, then check the registered result just after the edge.
  task automatic strobe(input string tag, input logic [15:0] x, input logic [15:0] exp_log);
    @(negedge clk);
    en    = 1'b1;
    ready = 1'b1;
    in_x  = x;
    @(posedge clk);
    #1;
    ready = 1'b0;
    check({tag, " log2"}, log2_x, exp_log);
    check({tag, " out_x"}, out_x, x);
    check({tag, " valid"}, 16'(valid), 16'h0001);
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b0;
    ready = 1'b0;
    in_x  = 16'h0000;
    #2 rst = 1'b0;
    #10;
    check("reset log2", log2_x, 16'h0000);
    check("reset out_x", out_x, 16'h0000);
    check("reset valid", 16'(valid), 16'h0000);
    @(negedge clk);
    rst = 1'b1;

    // A result of 1.0 is available one cycle later, and valid is a single pulse.
    strobe("one", 16'h1000, 16'h0000);
    @(posedge clk);
    #1;
    check("pulse valid", 16'(valid), 16'h0000);
    check("pulse hold log2", log2_x, 16'h0000);
    check("pulse hold out_x", out_x, 16'h1000);

    // Powers of two.
    strobe("p2_0040", 16'h0040, 16'hA000);
    strobe("p2_0100", 16'h0100, 16'hC000);
    strobe("p2_2000", 16'h2000, 16'h1000);
    strobe("p2_8000", 16'h8000, 16'h3000);

    // Values that are not powers of two.
`ifdef LOG2_APPROX_CORR_EN
    strobe("np_00C0", 16'h00C0, 16'hB960);
    strobe("np_5000", 16'h5000, 16'h2508);
`else
    strobe("np_00C0", 16'h00C0, 16'hB800);
    strobe("np_5000", 16'h5000, 16'h2400);
`endif
    strobe("np_FFFF", 16'hFFFF, 16'h3FFF);

    // Saturation boundary.
    strobe("sat_0000", 16'h0000, 16'h8000);
    strobe("sat_000F", 16'h000F, 16'h8000);
    strobe("sat_0010", 16'h0010, 16'h8000);
    strobe("sat_0008", 16'h0008, 16'h8000);

    // Three strobes back to back.
    @(negedge clk);
    en    = 1'b1;
    ready = 1'b1;
    in_x  = 16'h1000;
    @(posedge clk);
    #1;
    check("b2b0 valid", 16'(valid), 16'h0001);
    check("b2b0 out_x", out_x, 16'h1000);
    check("b2b0 log2", log2_x, 16'h0000);
    @(negedge clk);
    in_x = 16'h2000;
    @(posedge clk);
    #1;
    check("b2b1 valid", 16'(valid), 16'h0001);
    check("b2b1 out_x", out_x, 16'h2000);
    check("b2b1 log2", log2_x, 16'h1000);
    @(negedge clk);
    in_x = 16'h0100;
    @(posedge clk);
    #1;
    check("b2b2 valid", 16'(valid), 16'h0001);
    check("b2b2 out_x", out_x, 16'h0100);
    check("b2b2 log2", log2_x, 16'hC000);
    @(negedge clk);
    ready = 1'b0;
    in_x  = 16'h8000;
    @(posedge clk);
    #1;
    check("b2b end valid", 16'(valid), 16'h0000);
    check("b2b end log2", log2_x, 16'hC000);
    check("b2b end out_x", out_x, 16'h0100);

    // With en low, every output is frozen, including a high valid.
    strobe("pre_freeze", 16'h2000, 16'h1000);
    @(negedge clk);
    en    = 1'b0;
    ready = 1'b1;
    in_x  = 16'h8000;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("freeze valid", 16'(valid), 16'h0001);
    check("freeze log2", log2_x, 16'h1000);
    check("freeze out_x", out_x, 16'h2000);
    @(negedge clk);
    en    = 1'b1;
    ready = 1'b0;
    @(posedge clk);
    #1;
    check("unfreeze valid", 16'(valid), 16'h0000);

    // Asserting reset mid-stream clears the outputs without a clock edge.
    strobe("pre_rst", 16'h5000,
`ifdef LOG2_APPROX_CORR_EN
           16'h2508
`else
           16'h2400
`endif
    );
    #2;
    rst = 1'b0;
    #1;
    check("async rst log2", log2_x, 16'h0000);
    check("async rst out_x", out_x, 16'h0000);
    check("async rst valid", 16'(valid), 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    strobe("post_rst", 16'h0040, 16'hA000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
